// File: rtl/tray_station_ctrl.sv
// rtl/tray_station_ctrl.sv - tray station positioning controller with settle, overshoot and timeout handling
module tray_station_ctrl #(
    parameter int N_STATION  = 8,
    parameter int HEIGHT_W   = 32,
    parameter int PITCH      = 100,
    parameter int TOL        = 2,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = 1000,
    localparam int SW        = $clog2(N_STATION)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          command,
    input  logic [SW-1:0]       cmd_station,
    input  logic [HEIGHT_W-1:0] tray_height,
    output logic [3:0]          icou,
    output logic [SW-1:0]       station,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int HW1     = HEIGHT_W + 1;
    localparam int EW      = HEIGHT_W + 2;
    localparam int SW1     = SW + 1;
    localparam int CNT_MAX = (TIMEOUT > SETTLE_CYC) ? TIMEOUT : SETTLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_GOTO      = 4'h1;
    localparam logic [3:0] OP_HOME      = 4'h2;
    localparam logic [3:0] OP_STEP_UP   = 4'h3;
    localparam logic [3:0] OP_STEP_DOWN = 4'h4;
    localparam logic [3:0] OP_CLEAR_ERR = 4'hF;

    localparam logic [3:0] ICOU_STOP  = 4'h0;
    localparam logic [3:0] ICOU_UP    = 4'h1;
    localparam logic [3:0] ICOU_DOWN  = 4'h2;
    localparam logic [3:0] ICOU_BRAKE = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_SETTLE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     station_q, station_d;
    logic [SW-1:0]     tgt_q, tgt_d;
    logic [HEIGHT_W:0] tgt_h_q, tgt_h_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              rdy_q;

    logic [SW-1:0]     acc_tgt;
    logic [HEIGHT_W:0] acc_h;
    logic              acc_motion;
    logic              acc_bad;
    logic              accept;

    // Height of a station index, widened by one bit so the top station never wraps.
    function automatic logic [HEIGHT_W:0] height_of(input logic [SW-1:0] idx);
        return HW1'(idx) * HW1'(PITCH);
    endfunction

    // True when the measured height lies inside the arrival window of the target.
    function automatic logic near(input logic [HEIGHT_W-1:0] h, input logic [HEIGHT_W:0] t);
        logic [EW-1:0] hx;
        logic [EW-1:0] tx;
        hx = EW'(h);
        tx = EW'(t);
        if (hx >= tx) begin
            return (hx - tx) <= EW'(TOL);
        end
        return (tx - hx) <= EW'(TOL);
    endfunction

    // True when the tray has gone past the top of the arrival window.
    function automatic logic above_win(input logic [HEIGHT_W-1:0] h, input logic [HEIGHT_W:0] t);
        return EW'(h) > (EW'(t) + EW'(TOL));
    endfunction

    // True when the tray has gone past the bottom of the arrival window.
    function automatic logic below_win(input logic [HEIGHT_W-1:0] h, input logic [HEIGHT_W:0] t);
        return (EW'(h) + EW'(TOL)) < EW'(t);
    endfunction

    // Reset release is taken through one flop so the first accept lands on the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Decode the offered command into a target station and a legality flag.
    always_comb begin
        acc_tgt    = station_q;
        acc_motion = 1'b0;
        acc_bad    = 1'b0;
        case (command)
            OP_GOTO: begin
                acc_tgt    = cmd_station;
                acc_motion = 1'b1;
                acc_bad    = ({1'b0, cmd_station} >= SW1'(N_STATION));
            end
            OP_HOME: begin
                acc_tgt    = '0;
                acc_motion = 1'b1;
            end
            OP_STEP_UP: begin
                if (station_q != SW'(N_STATION - 1)) begin
                    acc_tgt = station_q + SW'(1);
                end
                acc_motion = 1'b1;
            end
            OP_STEP_DOWN: begin
                if (station_q != '0) begin
                    acc_tgt = station_q - SW'(1);
                end
                acc_motion = 1'b1;
            end
            OP_NOP, OP_CLEAR_ERR: begin
                acc_motion = 1'b0;
            end
            default: begin
                acc_bad = 1'b1;
            end
        endcase
    end

    assign acc_h  = height_of(acc_tgt);
    assign accept = cmd_valid && cmd_ready;

    // Next-state logic: accept in IDLE, track arrival/overshoot/timeout, hold brake, recover from ERROR.
    always_comb begin
        state_d   = state_q;
        station_d = station_q;
        tgt_d     = tgt_q;
        tgt_h_d   = tgt_h_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (acc_bad) begin
                        state_d = S_ERROR;
                    end else if (acc_motion) begin
                        if (near(tray_height, acc_h)) begin
                            station_d = acc_tgt;
                            done_d    = 1'b1;
                        end else begin
                            tgt_d   = acc_tgt;
                            tgt_h_d = acc_h;
                            cnt_d   = '0;
                            state_d = (EW'(tray_height) < EW'(acc_h)) ? S_MOVE_UP : S_MOVE_DOWN;
                        end
                    end
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (near(tray_height, tgt_h_q)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if ((state_q == S_MOVE_UP) ? above_win(tray_height, tgt_h_q)
                                                    : below_win(tray_height, tgt_h_q)) begin
                    state_d = S_ERROR;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    state_d   = S_IDLE;
                    station_d = tgt_q;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ERROR: begin
                if (accept && (command == OP_CLEAR_ERR)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops drive at once with no settle phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            station_q <= '0;
            tgt_q     <= '0;
            tgt_h_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            station_q <= station_d;
            tgt_q     <= tgt_d;
            tgt_h_q   <= tgt_h_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    // Drive code follows the state directly.
    always_comb begin
        icou = ICOU_STOP;
        case (state_q)
            S_MOVE_UP:   icou = ICOU_UP;
            S_MOVE_DOWN: icou = ICOU_DOWN;
            S_SETTLE:    icou = ICOU_BRAKE;
            default:     icou = ICOU_STOP;
        endcase
    end

    assign cmd_ready = rdy_q && ((state_q == S_IDLE) || (state_q == S_ERROR));
    assign busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign err       = (state_q == S_ERROR);
    assign done      = done_q;
    assign station   = station_q;

endmodule

// File: tb/tb_tray_station_ctrl.sv
// tb/tb_tray_station_ctrl.sv - bench for tray_station_ctrl with a height plant and outcome model
module tb_tray_station_ctrl;

    localparam int N       = 8;
    localparam int PITCH   = 100;
    localparam int TOL     = 2;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1000;

    localparam int K_NONE = 0;
    localparam int K_NOW  = 1;
    localparam int K_MOVE = 2;
    localparam int K_ERR  = 3;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  command;
    logic [2:0]  cmd_station;
    logic [31:0] tray_height;
    logic [3:0]  icou;
    logic [2:0]  station;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;
    int m_station;
    bit m_err;
    int exp_kind;
    int exp_up;
    int exp_dn;
    int exp_br;
    int cur_h;

    tray_station_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .command    (command),
        .cmd_station(cmd_station),
        .tray_height(tray_height),
        .icou       (icou),
        .station    (station),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Outcome model: predicts the result of a command from the rules, given start height and plant rate.
    task automatic predict(input logic [3:0] op, input int st, input int h0, input int r);
        int t;
        int th;
        int hk;
        bit up;
        exp_up = 0;
        exp_dn = 0;
        exp_br = 0;
        if (m_err) begin
            exp_kind = K_NONE;
            if (op == 4'hF) m_err = 0;
            return;
        end
        case (op)
            4'h0, 4'hF: begin exp_kind = K_NONE; return; end
            4'h1: begin
                if (st >= N) begin exp_kind = K_ERR; m_err = 1; return; end
                t = st;
            end
            4'h2: t = 0;
            4'h3: t = (m_station + 1 > N - 1) ? N - 1 : m_station + 1;
            4'h4: t = (m_station - 1 < 0) ? 0 : m_station - 1;
            default: begin exp_kind = K_ERR; m_err = 1; return; end
        endcase
        th = t * PITCH;
        if (iabs(h0 - th) <= TOL) begin
            exp_kind = K_NOW;
            m_station = t;
            return;
        end
        up = (h0 < th);
        for (int k = 1; k <= TIMEOUT; k++) begin
            hk = up ? h0 + k * r : ((h0 - k * r < 0) ? 0 : h0 - k * r);
            if (iabs(hk - th) <= TOL) begin
                exp_kind = K_MOVE;
                if (up) exp_up = k; else exp_dn = k;
                exp_br = SETTLE;
                m_station = t;
                return;
            end
            if ((up && hk > th + TOL) || (!up && hk < th - TOL)) begin
                exp_kind = K_ERR;
                if (up) exp_up = k; else exp_dn = k;
                m_err = 1;
                return;
            end
        end
        exp_kind = K_ERR;
        if (up) exp_up = TIMEOUT; else exp_dn = TIMEOUT;
        m_err = 1;
    endtask

    // Observe from the first sample after the accepting edge, moving the plant while the DUT drives.
    task automatic monitor(input int r);
        int cyc;
        int up;
        int dn;
        int br;
        int bad;
        cyc = 0; up = 0; dn = 0; br = 0; bad = 0;
        if (exp_kind == K_NONE) begin
            repeat (3) begin
                if (done !== 1'b0 || icou !== 4'h0 || busy !== 1'b0) bad++;
                @(negedge clk);
            end
            check("none_quiet", bad, 0);
            check("none_err", err, m_err);
            check("none_station", station, m_station);
            return;
        end
        while (cyc < 1500 && done !== 1'b1 && err !== 1'b1) begin
            if (cmd_ready === 1'b1) bad++;
            if (busy !== 1'b1) bad++;
            case (icou)
                4'h1: begin up++; cur_h = cur_h + r; end
                4'h2: begin dn++; cur_h = (cur_h < r) ? 0 : cur_h - r; end
                4'h4: br++;
                default: bad++;
            endcase
            tray_height = cur_h;
            @(negedge clk);
            cyc++;
        end
        check("bounded", cyc < 1500, 1);
        check("done", done, (exp_kind == K_NOW || exp_kind == K_MOVE));
        check("err", err, m_err);
        check("up_cycles", up, exp_up);
        check("down_cycles", dn, exp_dn);
        check("brake_cycles", br, exp_br);
        check("station", station, m_station);
        check("icou_end", icou, 0);
        check("busy_end", busy, 0);
        check("protocol", bad, 0);
        if (exp_kind != K_ERR) begin
            @(negedge clk);
            check("done_pulse", done, 0);
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input int st, input int h0, input int r);
        predict(op, st, h0, r);
        @(negedge clk);
        cur_h = h0;
        tray_height = h0;
        cmd_valid = 1'b1;
        command = op;
        cmd_station = st[2:0];
        #1 check("ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        monitor(r);
    endtask

    initial begin
        int sel;
        int op;
        int st;
        int h0;
        int r;
        int tmp;
        checks = 0;
        errors = 0;
        m_station = 0;
        m_err = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        command = 4'h0;
        cmd_station = 3'd0;
        tray_height = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_icou", icou, 0);
        check("rst_station", station, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", cmd_ready, 0);

        // GOTO 3 from height 0 held across reset release: accepted on the second edge.
        predict(4'h1, 3, 0, 10);
        cur_h = 0;
        cmd_valid = 1'b1;
        command = 4'h1;
        cmd_station = 3'd3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("sync_ready", cmd_ready, 1);
        check("sync_not_taken", busy, 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("goto3_up", icou, 1);
        monitor(10);

        // HOME from station 5 at height 500.
        run_cmd(4'h1, 5, 500, 0);
        run_cmd(4'h2, 0, 500, 10);

        // STEP_UP at the top station and STEP_DOWN at station 0 complete in place.
        run_cmd(4'h1, 7, 700, 0);
        run_cmd(4'h3, 0, 700, 0);
        run_cmd(4'h2, 0, 1, 0);
        run_cmd(4'h4, 0, 2, 0);

        // Frozen height times out; CLEAR_ERR recovers; CLEAR_ERR and NOP in IDLE do nothing.
        run_cmd(4'h1, 3, 0, 0);
        run_cmd(4'h1, 6, 0, 0);
        run_cmd(4'hF, 0, 0, 0);
        run_cmd(4'hF, 0, 0, 0);
        run_cmd(4'h0, 0, 0, 0);

        // Overshoot on a jump 150 -> 210 toward station 2, then an illegal opcode.
        run_cmd(4'h1, 2, 150, 60);
        run_cmd(4'hF, 0, 0, 0);
        run_cmd(4'h9, 0, 0, 0);
        run_cmd(4'hF, 0, 0, 0);

        // Reset asserted during MOVE_DOWN.
        run_cmd(4'h1, 5, 500, 0);
        @(negedge clk);
        tray_height = 32'd500;
        cmd_valid = 1'b1;
        command = 4'h2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_down", icou, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_icou", icou, 0);
        check("midrst_busy", busy, 0);
        check("midrst_station", station, 0);
        check("midrst_err", err, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_station = 0;
        m_err = 0;

        // Randomised command stream.
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 8) op = 1;
            else if (sel < 10) op = 2;
            else if (sel < 13) op = 3;
            else if (sel < 16) op = 4;
            else if (sel == 16) op = 0;
            else if (sel == 17) op = 15;
            else op = int'($urandom_range(5, 14));
            if (m_err && $urandom_range(0, 1) == 1) op = 15;
            st = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                tmp = int'($urandom_range(0, 6));
                h0 = int'($urandom_range(0, 7)) * PITCH + tmp - 3;
            end else begin
                h0 = int'($urandom_range(0, 800));
            end
            if (h0 < 0) h0 = 0;
            r = int'($urandom_range(3, 40));
            run_cmd(op[3:0], st, h0, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
